div_ctrl: RTL and testbench
===========================

# div_ctrl

Sequencing controller for the multi-cycle radix-2 divider in the EX stage of the 5-stage MIPS pipeline. It accepts a DIV/DIVU from EX and drives the divider's start/annul handshake. It stalls IF..EX until the divider finishes, then writes the remainder/quotient pair to HI/LO with a single-cycle write strobe. It also kills an in-flight division on pipeline flush and aborts a hung divider after a watchdog timeout.

## Interface
- TIMEOUT, 48, max BUSY cycles without div_ready before abort; legal 36..63
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- ex_div_valid  in  1  EX holds a DIV/DIVU instruction
- ex_div_signed  in  1  1 = DIV, 0 = DIVU
- ex_op1  in  32  dividend (rs)
- ex_op2  in  32  divisor (rt)
- flush  in  1  pipeline flush; kills the instruction in EX
- stall_req  out  1  hold IF/ID/EX (combinational)
- div_start  out  1  divider start level
- div_annul  out  1  divider annul (combinational)
- div_signed  out  1  latched signedness
- div_op1  out  32  latched dividend
- div_op2  out  32  latched divisor
- div_result  in  64  {remainder, quotient}
- div_ready  in  1  divider result valid
- hilo_we  out  1  HI/LO write strobe, one cycle
- hi_o  out  32  remainder = div_result[63:32]
- lo_o  out  32  quotient = div_result[31:0]
- err_o  out  1  one-cycle pulse on watchdog abort

## Operation
- States: IDLE, BUSY, DONE. Reset → IDLE.
- Divider contract:
  - div_start must be held high until div_ready.
  - Dropping div_start after div_ready returns the divider to free on the next edge.
  - div_annul high during computation returns it to free.
- IDLE:
  - If ex_div_valid && !flush: latch ex_op1/ex_op2/ex_div_signed into div_op1/div_op2/div_signed. Assert div_start and stall_req this cycle; div_op* show the EX values combinationally in this cycle. Clear cnt. Next state BUSY.
  - Otherwise stay in IDLE with all strobes low.
- BUSY:
  - div_start = 1, stall_req = 1, div_op* held from latches, cnt increments each cycle.
  - Priority 1, flush = 1: div_annul = 1, div_start = 0, no HI/LO write, next state IDLE.
  - Priority 2, div_ready = 1: register hi_o/lo_o from div_result, next state DONE.
  - Priority 3, cnt == TIMEOUT-1 with no ready: div_annul = 1, div_start = 0, err_o pulses the next cycle, next state IDLE.
- DONE:
  - hilo_we = 1, div_start = 0, stall_req = 0. The DIV leaves EX at this edge. ex_div_valid is ignored.
  - flush in DONE does not suppress hilo_we; the result is architecturally committed.
  - Next state IDLE.
- Divide-by-zero: no special casing. The divider returns 0, so HI = LO = 0 is written.
- hi_o/lo_o hold their value outside DONE.

## Timing
- Reset values: stall_req 0, div_start 0, div_annul 0, hilo_we 0, err_o 0, hi_o/lo_o 0, div_op*/div_signed 0, cnt 0. While rst = 1, stall_req = 0 and div_annul = 0 regardless of inputs.
- Nominal divider latency: div_ready first high 35 cycles after the first div_start cycle (3 for divisor 0). The controller does not depend on the exact value.
- Nominal non-zero DIV, cycle 0 = IDLE accept:
  - stall_req high cycles 0..35 (36 cycles).
  - hilo_we high in cycle 36 only.
  - IDLE from cycle 37.
- Back-to-back DIVs: the next accept occurs in the cycle after DONE, when the divider is free.
- Reset mid-BUSY: IDLE next cycle, all outputs at reset values, no hilo_we. rst is shared with the divider.
- flush and ex_div_valid together in IDLE: not accepted, no stall.

## Test plan
- DIVU 100/7 → stall_req high 36 cycles; hilo_we single pulse in cycle 36 with hi_o = 2, lo_o = 14.
- DIV −7/2 (0xFFFFFFF9, 2) → lo_o = 0xFFFFFFFD, hi_o = 0xFFFFFFFF; DIV 7/−2 → lo_o = 0xFFFFFFFD, hi_o = 1.
- DIVU 5/0 → hilo_we pulse with hi_o = lo_o = 0; stall_req high 4 cycles.
- DIV 1000/3 with flush in BUSY cycle 10 → div_annul high that cycle, no hilo_we. A following DIVU 9/3 completes with lo_o = 3, hi_o = 0.
- Divider model with div_ready tied low, TIMEOUT = 48 → div_annul after 48 BUSY cycles, err_o one-cycle pulse, stall_req drops, no hilo_we.
- Two consecutive DIVU (50/5, 51/5) → two hilo_we pulses 37 cycles apart: (hi 0, lo 10) then (hi 1, lo 10). rst asserted mid-second → outputs return to reset values the next cycle.

Source files
------------

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - DIV/DIVU sequencing controller for the multi-cycle radix-2 divider
module div_ctrl #(
    parameter int TIMEOUT = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div_valid,
    input  logic        ex_div_signed,
    input  logic [31:0] ex_op1,
    input  logic [31:0] ex_op2,
    input  logic        flush,
    output logic        stall_req,
    output logic        div_start,
    output logic        div_annul,
    output logic        div_signed,
    output logic [31:0] div_op1,
    output logic [31:0] div_op2,
    input  logic [63:0] div_result,
    input  logic        div_ready,
    output logic        hilo_we,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic        r_signed;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_hilo_we;
    logic        r_err;

    logic w_accept;
    logic w_busy;
    logic w_timeout;
    logic w_abort;

    // Everything combinational is gated by rst so a shared reset never stalls or annuls.
    assign w_accept  = !rst && (r_state == S_IDLE) && ex_div_valid && !flush;
    assign w_busy    = !rst && (r_state == S_BUSY);
    assign w_timeout = (r_cnt == 6'(TIMEOUT - 1));
    assign w_abort   = w_busy && (flush || (!div_ready && w_timeout));

    assign stall_req  = w_accept || w_busy;
    assign div_start  = w_accept || (w_busy && !w_abort);
    assign div_annul  = w_abort;
    assign div_op1    = w_accept ? ex_op1 : r_op1;
    assign div_op2    = w_accept ? ex_op2 : r_op2;
    assign div_signed = w_accept ? ex_div_signed : r_signed;
    assign hilo_we    = r_hilo_we;
    assign hi_o       = r_hi;
    assign lo_o       = r_lo;
    assign err_o      = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 6'd0;
            r_op1     <= 32'd0;
            r_op2     <= 32'd0;
            r_signed  <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_hilo_we <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_hilo_we <= 1'b0;
            r_err     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ex_div_valid && !flush) begin
                        r_op1    <= ex_op1;
                        r_op2    <= ex_op2;
                        r_signed <= ex_div_signed;
                        r_cnt    <= 6'd0;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else if (div_ready) begin
                        r_hi      <= div_result[63:32];
                        r_lo      <= div_result[31:0];
                        r_hilo_we <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    // Result is committed here even if a flush arrives; EX input is ignored.
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - self-checking bench for div_ctrl with a behavioural divider model
module tb_div_ctrl;
    localparam int TO = 48;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_div_valid;
    logic        ex_div_signed;
    logic [31:0] ex_op1;
    logic [31:0] ex_op2;
    logic        flush;
    logic        stall_req;
    logic        div_start;
    logic        div_annul;
    logic        div_signed;
    logic [31:0] div_op1;
    logic [31:0] div_op2;
    logic [63:0] div_result;
    logic        div_ready;
    logic        hilo_we;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        err_o;

    int total = 0;
    int bad   = 0;
    int g_cyc = 0;
    int g_last_hilo = 0;

    always #5 clk = ~clk;
    always @(posedge clk) g_cyc <= g_cyc + 1;

    div_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ex_div_valid(ex_div_valid), .ex_div_signed(ex_div_signed),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .flush(flush),
        .stall_req(stall_req), .div_start(div_start), .div_annul(div_annul),
        .div_signed(div_signed), .div_op1(div_op1), .div_op2(div_op2),
        .div_result(div_result), .div_ready(div_ready),
        .hilo_we(hilo_we), .hi_o(hi_o), .lo_o(lo_o), .err_o(err_o)
    );

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return 64'd0;
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
        if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Divider model: busy from first start, ready after latency, freed by start drop, annul or rst.
    int          lat_cfg = 35;
    bit          m_never = 1'b0;
    bit          m_busy  = 1'b0;
    int          m_k     = 0;
    int          m_lat   = 35;
    logic [63:0] m_res   = 64'd0;
    logic        m_ready = 1'b0;

    assign div_ready  = m_ready;
    assign div_result = m_ready ? m_res : 64'd0;

    always @(posedge clk) begin
        if (rst || div_annul) begin
            m_busy  <= 1'b0;
            m_ready <= 1'b0;
            m_k     <= 0;
        end else if (!m_busy) begin
            if (div_start) begin
                m_busy  <= 1'b1;
                m_k     <= 1;
                m_lat   <= (div_op2 == 32'd0) ? 3 : lat_cfg;
                m_res   <= ref_div(div_op1, div_op2, div_signed);
                m_ready <= 1'b0;
            end
        end else if (m_ready && !div_start) begin
            m_busy  <= 1'b0;
            m_ready <= 1'b0;
        end else begin
            m_k     <= m_k + 1;
            m_ready <= !m_never && (m_k + 1 >= m_lat);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One DIV issued at the current cycle (entered just after a rising edge).
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int flush_at, input int lat, input bit never);
        int eff, last_c, last_valid;
        int stall_n, hilo_n, hilo_c, annul_n, annul_c, err_n, err_c;
        logic [31:0] got_hi, got_lo;
        logic [63:0] er;
        eff = (b == 32'd0) ? 3 : lat;
        er  = ref_div(a, b, s);
        lat_cfg = lat;
        m_never = never;
        if (flush_at > 0) last_c = flush_at + 1;
        else if (never)   last_c = TO + 1;
        else              last_c = eff + 1;
        last_valid = (flush_at > 0 || never) ? last_c - 1 : last_c;
        stall_n = 0; hilo_n = 0; hilo_c = -1; annul_n = 0; annul_c = -1; err_n = 0; err_c = -1;
        got_hi = 32'd0; got_lo = 32'd0;
        ex_op1 = a; ex_op2 = b; ex_div_signed = s;
        for (int c = 0; c <= last_c; c++) begin
            ex_div_valid = (c <= last_valid);
            flush = (c == flush_at);
            @(negedge clk);
            if (c == 0) begin
                chk("accept_start_op1", {31'd0, div_start, div_op1}, {31'd0, 1'b1, a});
                chk("accept_op2_sgn", {31'd0, div_signed, div_op2}, {31'd0, s, b});
            end
            if (stall_req) stall_n++;
            if (hilo_we) begin
                hilo_n++; hilo_c = c; got_hi = hi_o; got_lo = lo_o; g_last_hilo = g_cyc;
            end
            if (div_annul) begin annul_n++; annul_c = c; end
            if (err_o) begin err_n++; err_c = c; end
            @(posedge clk); #1;
        end
        ex_div_valid = 1'b0;
        flush = 1'b0;
        if (flush_at > 0) begin
            chk("flush_stall_cycles", stall_n, flush_at + 1);
            chk("flush_annul", {annul_n, annul_c}, {32'd1, 32'(flush_at)});
            chk("flush_no_hilo", hilo_n, 0);
            chk("flush_no_err", err_n, 0);
        end else if (never) begin
            chk("to_stall_cycles", stall_n, TO + 1);
            chk("to_annul", {annul_n, annul_c}, {32'd1, 32'(TO)});
            chk("to_err_pulse", {err_n, err_c}, {32'd1, 32'(TO + 1)});
            chk("to_no_hilo", hilo_n, 0);
        end else begin
            chk("stall_cycles", stall_n, eff + 1);
            chk("hilo_pulse", {hilo_n, hilo_c}, {32'd1, 32'(eff + 1)});
            chk("hilo_value", {got_hi, got_lo}, er);
            chk("no_annul_err", {annul_n, err_n}, 64'd0);
        end
    endtask

    int          t1;
    logic [31:0] ra, rb;
    logic        rs;
    logic [63:0] last_res;

    initial begin
        rst = 1'b1; ex_div_valid = 1'b0; ex_div_signed = 1'b0;
        ex_op1 = 32'd0; ex_op2 = 32'd0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        ex_div_valid = 1'b1; ex_op1 = 32'd5; ex_op2 = 32'd1;
        @(negedge clk);
        chk("rst_gates_stall_annul", {stall_req, div_annul}, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0; ex_div_valid = 1'b0;
        @(negedge clk);
        chk("reset_strobes", {stall_req, div_start, div_annul, hilo_we, err_o}, 5'b0);
        chk("reset_hilo", {hi_o, lo_o}, 64'd0);
        chk("reset_ops", {31'd0, div_signed, div_op1}, 64'd0);
        @(posedge clk); #1;

        do_div(32'd100, 32'd7, 1'b0, -1, 35, 1'b0);
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1, -1, 35, 1'b0);
        do_div(32'd7, 32'hFFFF_FFFE, 1'b1, -1, 35, 1'b0);
        do_div(32'd5, 32'd0, 1'b0, -1, 35, 1'b0);
        do_div(32'd1000, 32'd3, 1'b1, 10, 35, 1'b0);
        do_div(32'd9, 32'd3, 1'b0, -1, 35, 1'b0);
        do_div(32'd77, 32'd4, 1'b0, -1, 35, 1'b1);
        m_never = 1'b0;

        // flush together with a new DIV in IDLE: not accepted
        ex_div_valid = 1'b1; flush = 1'b1; ex_op1 = 32'd8; ex_op2 = 32'd2;
        @(negedge clk);
        chk("idle_flush_no_accept", {stall_req, div_start}, 2'b00);
        @(posedge clk); #1;
        ex_div_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("idle_flush_stays_idle", {stall_req, div_start, hilo_we}, 3'b000);
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            if (i == 2) rb = 32'd0;
            rs = 1'($urandom_range(0, 1));
            do_div(ra, rb, rs, -1, $urandom_range(2, 45), 1'b0);
            last_res = ref_div(ra, rb, rs);
        end
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("hilo_hold_idle", {hi_o, lo_o}, last_res);
        @(posedge clk); #1;

        do_div(32'd50, 32'd5, 1'b0, -1, 35, 1'b0);
        t1 = g_last_hilo;
        do_div(32'd51, 32'd5, 1'b0, -1, 35, 1'b0);
        chk("b2b_hilo_gap", g_last_hilo - t1, 37);

        // reset in the middle of a third division
        ex_div_valid = 1'b1; ex_op1 = 32'd51; ex_op2 = 32'd5; ex_div_signed = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midbusy_rst_comb", {stall_req, div_annul}, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0; ex_div_valid = 1'b0;
        @(negedge clk);
        chk("midbusy_rst_strobes", {stall_req, div_start, hilo_we, err_o}, 4'b0);
        chk("midbusy_rst_hilo", {hi_o, lo_o}, 64'd0);
        chk("midbusy_rst_ops", {div_op1, div_op2}, 64'd0);
        @(posedge clk); #1;
        do_div(32'd9, 32'd3, 1'b0, -1, 35, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
